// File: rtl/demux_1xn_stream.sv
// rtl/demux_1xn_stream.sv - registered 1-to-N stream demux with addressed and round-robin modes
module demux_1xn_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     d,
  input  logic [SEL_W-1:0]     sel,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [N*WIDTH-1:0]   y,
  output logic [SEL_W-1:0]     rr_ptr,
  output logic                 drop_err
);

  localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

  logic [SEL_W-1:0]   tgt;
  logic               tgt_ok;
  logic               accept;
  logic [N-1:0]       hit;
  logic [N-1:0]       out_valid_d, out_valid_q;
  logic [N*WIDTH-1:0] y_d, y_q;
  logic [SEL_W-1:0]   rr_ptr_d, rr_ptr_q;
  logic               drop_err_d, drop_err_q;

  assign tgt    = mode ? rr_ptr_q : sel;
  assign tgt_ok = {1'b0, tgt} < N_EXT;

  // One-hot target decode; an out-of-range target hits no channel, so it is always ready
  assign in_ready = ~|(hit & out_valid_q & ~out_ready);
  assign accept   = in_valid && in_ready && tgt_ok;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic wr;
    assign hit[i]                 = tgt_ok && (tgt == SEL_W'(i));
    assign wr                     = accept && hit[i];
    assign out_valid_d[i]         = wr | (out_valid_q[i] & ~out_ready[i]);
    assign y_d[i*WIDTH +: WIDTH]  = wr ? d : y_q[i*WIDTH +: WIDTH];
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && mode) begin
      rr_ptr_d = (rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + SEL_W'(1);
    end
    drop_err_d = in_valid && !tgt_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      y_q         <= '0;
      rr_ptr_q    <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      rr_ptr_q    <= rr_ptr_d;
      drop_err_q  <= drop_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign rr_ptr    = rr_ptr_q;
  assign drop_err  = drop_err_q;

endmodule

// File: doc/demux_1xn_stream.md
Name: demux_1xn_stream

Overview:
Parametrised, registered 1-to-N demultiplexer for data streams. It is the successor to the combinational 1x8 demux and adds a WIDTH-bit data path and N output channels. Each channel has a one-entry holding register with a valid/ready handshake. The block has an addressed mode and a round-robin distribution mode, and flags any word sent to a non-existent channel. It sits between a single producer and N independent consumers.

Parameters:
WIDTH, 8, data word width in bits
N, 8, number of output channels (2..16, need not be a power of 2)
SEL_W, 3, select width; must satisfy 2**SEL_W >= N

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
mode  input  1  0 = addressed (use sel), 1 = round-robin (use rr_ptr)
in_valid  input  1  producer has a word on d
in_ready  output  1  block accepts d this cycle (combinational)
d  input  WIDTH  input data word
sel  input  SEL_W  target channel in addressed mode
out_valid  output  N  bit i set = channel i holds a word
out_ready  input  N  bit i set = consumer i takes its word this cycle
y  output  N*WIDTH  channel i data on y[i*WIDTH +: WIDTH]
rr_ptr  output  SEL_W  next round-robin target channel
drop_err  output  1  one-cycle pulse, word dropped due to invalid sel

Behaviour:
- Clocking and reset
  - Single clock; all state updates on the rising edge of clk.
  - Reset is synchronous and active-low. On rst_n = 0 at an edge: out_valid = 0, every y slice = 0, rr_ptr = 0, drop_err = 0.
  - Reset mid-operation discards all held words, even if out_ready is asserted in that cycle.
- Target selection: tgt = mode ? rr_ptr : sel. This is evaluated combinationally, so a mode change takes effect in the same cycle. rr_ptr keeps its value across mode changes.
- Invalid target
  - tgt >= N is possible only in addressed mode when N < 2**SEL_W.
  - In that case in_ready = 1. On in_valid the word is consumed and dropped; no channel state changes.
  - drop_err = 1 in the following cycle only.
- Valid target: in_ready = !out_valid[tgt] || out_ready[tgt]. This is a pass-through, so a full slot that is being drained in the same cycle can be refilled.
- Accept condition: accept = in_valid && in_ready && (tgt < N). On accept:
  - y slice tgt <= d.
  - out_valid[tgt] <= 1.
  - Latency is one cycle: the word is visible on y in the cycle after acceptance.
- Drain: for each channel i not being written, out_valid[i] && out_ready[i] clears out_valid[i] at the next edge. The y slice keeps its last value; it is not cleared.
- Simultaneous drain and fill on the same channel: out_valid stays 1 and y takes the new word, with no bubble.
- out_ready[i] while out_valid[i] = 0 has no effect.
- Round-robin pointer
  - rr_ptr advances only on accept in mode 1: rr_ptr <= (rr_ptr == N-1) ? 0 : rr_ptr + 1.
  - rr_ptr does not advance on stall, in mode 0, or on a dropped word.
- drop_err is cleared every cycle it is not being set. It never asserts in mode 1.
- Backpressure: a stall on one channel blocks the producer only while that channel is the current target. Other channels continue to drain independently.
- Holding behaviour: in_valid may drop without an accept (no data loss by the block). d and sel are sampled only in the accept cycle.
- Implementation constraints:
  - Per-channel logic uses a generate loop over N.
  - The accept path has no combinational loop from out_ready to in_ready other than the stated pass-through.

Test Plan:
- Reset, then addressed sweep.
  - Stimulus: rst_n = 0 for 2 cycles; WIDTH=8, N=8; mode 0, out_ready = 8'hFF, d = 8'hA5, sel stepped 0..7, one per cycle.
  - Response: each cycle exactly one out_valid bit set (bit k, one cycle after sel = k) with y slice k = 8'hA5; rr_ptr stays 0.
- Backpressure and pass-through.
  - Stimulus: mode 0, sel = 3, out_ready[3] = 0; send 8'h11, then 8'h22.
  - Response: 8'h11 held on slice 3 and in_ready = 0; when out_ready[3] rises, in_ready = 1 the same cycle and slice 3 = 8'h22 next cycle with out_valid[3] still 1.
- Round-robin wrap.
  - Stimulus: mode 1, out_ready all 1; send d = 0..9.
  - Response: d=0..7 land on channels 0..7 and d=8,9 land on channels 0,1; rr_ptr reads 2 at end.
- Round-robin stall.
  - Stimulus: mode 1, out_ready[rr_ptr] = 0 with that slot full.
  - Response: in_ready = 0 and rr_ptr frozen; other channels keep draining.
- Invalid select.
  - Stimulus: N=6, SEL_W=3, mode 0, sel = 7, in_valid = 1, d = 8'h3C.
  - Response: in_ready = 1, drop_err = 1 for one cycle, out_valid unchanged.
- Reset mid-operation.
  - Stimulus: channels 2 and 5 full, rst_n = 0 for one edge.
  - Response: out_valid = 0, y = 0, rr_ptr = 0 at the next cycle.
